// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_tx_arbiter_pkg;

    localparam int UART_WIDTH = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the arbiter, bundled with master/slave views.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = UART_WIDTH
) ();

    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ*WIDTH-1:0] i_req_data;
    logic [N_REQ-1:0]       i_req_last;
    logic [N_REQ-1:0]       o_req_ready;
    logic [WIDTH-1:0]       o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;
    logic [N_REQ-1:0]       o_grant;
    logic                   o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after last_idx+1, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W:0]   w_sum  [N];
    logic [IDX_W-1:0] w_cand [N];

    // Candidate gi is the (gi+1)-th index after the last owner; sum < 2N so one subtract wraps it.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, i_last_idx} + (IDX_W+1)'(gi + 1);
            assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(N))
                                ? IDX_W'(w_sum[gi] - (IDX_W+1)'(N))
                                : IDX_W'(w_sum[gi]);
        end
    endgenerate

    always_comb begin
        o_idx    = '0;
        o_any    = 1'b0;
        o_onehot = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[w_cand[j]]) begin
                o_idx = w_cand[j];
                o_any = 1'b1;
            end
        end
        o_onehot[o_idx] = o_any;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among N_REQ byte streams,
// with a one-entry holding register in front of the transmitter.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int WIDTH     = UART_WIDTH,
    parameter int MAX_BURST = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int CNT_W = (MAX_BURST == 0) ? 1 : clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_tx_valid;

    logic [WIDTH-1:0] w_req_byte [N_REQ];
    logic [N_REQ-1:0] w_win_onehot;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_any;
    logic             w_hold_free;
    logic             w_accept;
    logic             w_sel_last;
    logic             w_burst_end;
    logic             w_release;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_req_byte[gi] = bus.i_req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req      (bus.i_req_valid),
        .i_last_idx (r_last_grant),
        .o_onehot   (w_win_onehot),
        .o_idx      (w_win_idx),
        .o_any      (w_win_any)
    );

    // The holder can take a byte when empty or when it is being emptied this same cycle.
    assign w_hold_free = ~r_tx_valid | bus.i_tx_ready;
    assign w_accept    = (r_state == ST_LOCKED) & w_hold_free & (|(r_grant & bus.i_req_valid));
    assign w_sel_last  = bus.i_req_last[r_owner];

    generate
        if (MAX_BURST != 0) begin : g_burst
            assign w_burst_end = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
        end else begin : g_no_burst
            assign w_burst_end = 1'b0;
        end
    endgenerate

    assign w_release = w_accept & (w_sel_last | w_burst_end);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_win_any) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_release) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_req_ready = '0;
        if (r_state == ST_LOCKED && w_hold_free) begin
            bus.o_req_ready = r_grant;
        end
        bus.o_busy = (r_state == ST_LOCKED) | r_tx_valid;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_burst_cnt  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_win_any) begin
                r_grant <= w_win_onehot;
                r_owner <= w_win_idx;
            end
        end else if (w_release) begin
            r_grant      <= '0;
            r_last_grant <= r_owner;
            r_burst_cnt  <= '0;
        end else if (w_accept && MAX_BURST != 0) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
    end

    // A simultaneous fire and accept reloads the holder, so valid stays high with no bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_accept) begin
            r_tx_data  <= w_req_byte[r_owner];
            r_tx_valid <= 1'b1;
        end else if (r_tx_valid && bus.i_tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_valid = r_tx_valid;
    assign bus.o_grant    = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (two requesters, MAX_BURST=4).
module tb_uart_tx_arbiter;

    logic clk;
    logic rst;

    uart_tx_arbiter_if #(.N_REQ(2), .WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .N_REQ     (2),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         failures;
    logic [7:0] pkt_data [2][32];
    bit         pkt_last [2][32];
    int         pkt_len  [2];
    int         ptr      [2];
    bit         req_en   [2];
    logic [7:0] out_log  [$];
    logic [7:0] exp_q    [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pkts();
        for (int k = 0; k < 2; k++) begin
            pkt_len[k] = 0;
            ptr[k]     = 0;
            req_en[k]  = 1'b0;
        end
    endtask

    task automatic add(input int k, input logic [7:0] d, input bit l);
        pkt_data[k][pkt_len[k]] = d;
        pkt_last[k][pkt_len[k]] = l;
        pkt_len[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            bit v;
            int p;
            v = req_en[k] && (ptr[k] < pkt_len[k]);
            p = (ptr[k] < 32) ? ptr[k] : 0;
            bus.i_req_valid[k]       = v;
            bus.i_req_data[k*8 +: 8] = v ? pkt_data[k][p] : 8'h00;
            bus.i_req_last[k]        = v & pkt_last[k][p];
        end
    endtask

    // Sample handshakes just before the edge, then advance requesters and redrive after it.
    task automatic cycle();
        logic [1:0] acc;
        acc = bus.o_req_ready & bus.i_req_valid;
        if (bus.o_tx_valid && bus.i_tx_ready) out_log.push_back(bus.o_tx_data);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (acc[k]) ptr[k]++;
        drive();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic exp_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, out_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (i < out_log.size()) ? {24'h0, out_log[i]} : 32'hdead, {24'h0, exp_q[i]});
        end
        $display("log %s: %0d bytes compared", tag, exp_q.size());
        exp_q.delete();
        out_log.delete();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_tx_valid"},  bus.o_tx_valid,  1'b0);
        chk({tag, "_tx_data"},   bus.o_tx_data,   8'h00);
        chk({tag, "_grant"},     bus.o_grant,     2'b00);
        chk({tag, "_req_ready"}, bus.o_req_ready, 2'b00);
        chk({tag, "_busy"},      bus.o_busy,      1'b0);
    endtask

    task automatic reset_pulse();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_pkts();
        drive();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_pkts();
        bus.i_tx_ready = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        bus.i_tx_ready = 1'b1;
        chk_cleared("reset");

        // Asynchronous reset mid-clock with random traffic in flight.
        for (int k = 0; k < 2; k++) begin
            req_en[k] = 1'b1;
            for (int i = 0; i < 4; i++) add(k, 8'($urandom), 1'b0);
        end
        drive();
        #1;
        run(3);
        chk("t1_pre_busy", bus.o_busy, 1'b1);
        chk("t1_pre_valid", bus.o_tx_valid, 1'b1);
        #3;
        bus.i_req_valid = 2'($urandom);
        bus.i_req_data  = 16'($urandom);
        bus.i_req_last  = 2'($urandom);
        bus.i_tx_ready  = 1'($urandom);
        rst = 1'b1;
        #1;
        chk_cleared("t1_async");
        $display("t1 async reset applied mid-clock");
        @(posedge clk);
        #1;
        clear_pkts();
        bus.i_tx_ready = 1'b1;
        drive();
        rst = 1'b0;
        #1;
        out_log.delete();

        // Single packet 48 49 0A, latency and grant timing.
        req_en[0] = 1'b1;
        add(0, 8'h48, 1'b0);
        add(0, 8'h49, 1'b0);
        add(0, 8'h0A, 1'b1);
        drive();
        #1;
        chk("t2_c0_grant", bus.o_grant, 2'b00);
        chk("t2_c0_valid", bus.o_tx_valid, 1'b0);
        cycle();
        chk("t2_c1_grant", bus.o_grant, 2'b01);
        chk("t2_c1_ready", bus.o_req_ready, 2'b01);
        chk("t2_c1_valid", bus.o_tx_valid, 1'b0);
        cycle();
        chk("t2_c2_valid", bus.o_tx_valid, 1'b1);
        chk("t2_c2_data", bus.o_tx_data, 8'h48);
        cycle();
        chk("t2_c3_data", bus.o_tx_data, 8'h49);
        chk("t2_c3_grant", bus.o_grant, 2'b01);
        cycle();
        chk("t2_c4_data", bus.o_tx_data, 8'h0A);
        chk("t2_c4_grant", bus.o_grant, 2'b00);
        chk("t2_c4_busy", bus.o_busy, 1'b1);
        cycle();
        chk("t2_c5_valid", bus.o_tx_valid, 1'b0);
        chk("t2_c5_busy", bus.o_busy, 1'b0);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h0A);
        chk_log("t2");

        // Contention after reset: req0 first, then req1, then rotation back to req0.
        reset_pulse();
        out_log.delete();
        req_en[0] = 1'b1;
        req_en[1] = 1'b1;
        add(0, 8'h41, 1'b0);
        add(0, 8'h42, 1'b1);
        add(1, 8'h78, 1'b0);
        add(1, 8'h79, 1'b1);
        drive();
        #1;
        cycle();
        chk("t3_first_grant", bus.o_grant, 2'b01);
        run(3);
        chk("t3_second_grant", bus.o_grant, 2'b10);
        run(10);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h79);
        chk_log("t3");
        clear_pkts();
        req_en[0] = 1'b1;
        req_en[1] = 1'b1;
        add(0, 8'h61, 1'b1);
        add(1, 8'h62, 1'b1);
        drive();
        #1;
        cycle();
        chk("t3_rotation_grant", bus.o_grant, 2'b01);
        run(8);
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        chk_log("t3b");

        // Burst limit of 4 forces a hand-over mid-stream.
        clear_pkts();
        req_en[0] = 1'b1;
        req_en[1] = 1'b1;
        for (int i = 0; i < 12; i++) add(0, 8'h50 + 8'(i), 1'b0);
        add(1, 8'hA0, 1'b0);
        add(1, 8'hA1, 1'b1);
        drive();
        #1;
        cycle();
        chk("t4_c1_grant", bus.o_grant, 2'b01);
        run(4);
        chk("t4_c5_grant", bus.o_grant, 2'b00);
        cycle();
        chk("t4_c6_grant", bus.o_grant, 2'b10);
        run(30);
        chk("t4_end_grant", bus.o_grant, 2'b00);
        chk("t4_end_busy", bus.o_busy, 1'b0);
        exp_seq(8'h50, 4);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_seq(8'h54, 8);
        chk_log("t4");

        // Backpressure: holder stays stable and no requester is ready while tx is stalled.
        clear_pkts();
        req_en[0] = 1'b1;
        add(0, 8'hC0, 1'b0);
        add(0, 8'hC1, 1'b0);
        add(0, 8'hC2, 1'b1);
        bus.i_tx_ready = 1'b0;
        drive();
        #1;
        cycle();
        chk("t5_c1_ready", bus.o_req_ready, 2'b01);
        cycle();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t5_stall%0d_data", i), bus.o_tx_data, 8'hC0);
            chk($sformatf("t5_stall%0d_ready", i), bus.o_req_ready, 2'b00);
            cycle();
        end
        bus.i_tx_ready = 1'b1;
        #1;
        run(8);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        chk_log("t5");

        // Reset after 2 of 5 bytes of req1; req0 must win first afterwards.
        clear_pkts();
        req_en[1] = 1'b1;
        for (int i = 0; i < 5; i++) add(1, 8'hD0 + 8'(i), (i == 4));
        drive();
        #1;
        for (int n = 0; n < 20 && ptr[1] < 2; n++) cycle();
        chk("t6_two_accepted", ptr[1], 2);
        #3;
        rst = 1'b1;
        #1;
        chk_cleared("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        pkt_len[0] = 0;
        ptr[0]     = 0;
        req_en[0]  = 1'b1;
        add(0, 8'hE0, 1'b1);
        drive();
        #1;
        out_log.delete();
        chk("t6_after_rst_grant", bus.o_grant, 2'b00);
        cycle();
        chk("t6_req0_first", bus.o_grant, 2'b01);
        run(15);
        exp_q.push_back(8'hE0);
        exp_seq(8'hD2, 3);
        chk_log("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
